// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decoder (master) and the immediate generator (slave).
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_instr;
  logic            in_prefix;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_ext;

  // Upstream decoder side: drives instructions, consumes immediates.
  modport master (
    output in_valid, in_instr, in_prefix, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_ext
  );

  // Immediate generator side.
  modport slave (
    input  in_valid, in_instr, in_prefix, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_ext
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: sign-extends the format-specific immediate of a
// 16-bit instruction to XLEN, optionally widened by a preceding EXT prefix.
// One registered output stage; in_ready follows out_ready combinationally.
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 16,
  parameter bit          PFX_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [0:0] {StNoPfx, StPfx} pfx_state_e;

  pfx_state_e      state_q, state_d;
  logic [12:0]     pfx_q, pfx_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic            out_ext_q, out_ext_d;

  logic            in_ready;
  logic            accept;
  logic            is_pfx;
  logic [2:0]      opcode;
  logic [XLEN-1:0] imm_unpfx;
  logic [XLEN-1:0] imm_pfx;

  assign opcode   = bus.in_instr[2:0];
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // With prefixes disabled the tag is ignored and every word is an ordinary instruction.
  assign is_pfx   = PFX_EN && bus.in_prefix;

  // Per-format immediates. The prefixed form replaces the instruction's sign bit with
  // the stored payload; the sized cast sign-extends from P[12] or truncates to XLEN.
  always_comb begin
    imm_unpfx = '0;
    imm_pfx   = '0;
    unique case (opcode)
      3'b000: begin
        imm_unpfx = XLEN'($signed(bus.in_instr[15:12]));
        imm_pfx   = XLEN'($signed({pfx_q, bus.in_instr[14:12]}));
      end
      3'b001: begin
        imm_unpfx = XLEN'($signed({bus.in_instr[15], bus.in_instr[13:9]}));
        imm_pfx   = XLEN'($signed({pfx_q, bus.in_instr[13:9]}));
      end
      3'b010, 3'b011: begin
        imm_unpfx = XLEN'($signed(bus.in_instr[15:9]));
        imm_pfx   = XLEN'($signed({pfx_q, bus.in_instr[14:9]}));
      end
      3'b100, 3'b101: begin
        imm_unpfx = XLEN'($signed({bus.in_instr[15:12], bus.in_instr[5:3]}));
        imm_pfx   = XLEN'($signed({pfx_q, bus.in_instr[14:12], bus.in_instr[5:3]}));
      end
      3'b110, 3'b111: begin
        imm_unpfx = XLEN'($signed(bus.in_instr[15:6]));
        imm_pfx   = XLEN'($signed({pfx_q, bus.in_instr[14:6]}));
      end
      default: begin
        imm_unpfx = '0;
        imm_pfx   = '0;
      end
    endcase
  end

  // Prefix FSM next state plus output-register load/drain; flush overrides all.
  always_comb begin
    state_d     = state_q;
    pfx_d       = pfx_q;
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_fmt_d   = out_fmt_q;
    out_ext_d   = out_ext_q;

    if (flush) begin
      state_d     = StNoPfx;
      pfx_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      // Beat consumed downstream; a load below may immediately refill it.
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (is_pfx) begin
          // Last prefix wins; no output beat for a prefix.
          state_d = StPfx;
          pfx_d   = bus.in_instr[15:3];
        end else begin
          state_d     = StNoPfx;
          out_valid_d = 1'b1;
          out_fmt_d   = opcode;
          unique case (state_q)
            StPfx: begin
              out_imm_d = imm_pfx;
              out_ext_d = 1'b1;
            end
            default: begin
              out_imm_d = imm_unpfx;
              out_ext_d = 1'b0;
            end
          endcase
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StNoPfx;
      pfx_q       <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= '0;
      out_ext_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pfx_q       <= pfx_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      out_ext_q   <= out_ext_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_fmt   = out_fmt_q;
  assign bus.out_ext   = out_ext_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (XLEN=16, XLEN=32, prefixes off)
// share one stimulus stream and are checked against hand-computed values.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_prefix;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  imm_gen_pipe_if #(.XLEN(16)) b16 ();
  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(16)) bnp ();

  assign b16.in_valid  = in_valid;
  assign b16.in_instr  = in_instr;
  assign b16.in_prefix = in_prefix;
  assign b16.out_ready = out_ready;
  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_prefix = in_prefix;
  assign b32.out_ready = out_ready;
  assign bnp.in_valid  = in_valid;
  assign bnp.in_instr  = in_instr;
  assign bnp.in_prefix = in_prefix;
  assign bnp.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(16), .PFX_EN(1'b1)) u16 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b16)
  );
  imm_gen_pipe #(.XLEN(32), .PFX_EN(1'b1)) u32 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (b32)
  );
  imm_gen_pipe #(.XLEN(16), .PFX_EN(1'b0)) unp (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bnp)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_prefix = 1'b0;
    in_instr  = 16'h0000;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present one word for exactly one cycle (accepted when in_ready is high).
  task automatic send(input logic [15:0] instr, input logic pfx);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_prefix = pfx;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    tick();
    n_cmp++;
    if (b16.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid16 got %b want 0", b16.out_valid);
    end
    n_cmp++;
    if (b32.out_imm !== 32'h0) begin
      n_err++; $display("FAIL reset_imm32 got %h want 00000000", b32.out_imm);
    end
    n_cmp++;
    if ({b16.out_fmt, b16.out_ext} !== 4'b0000) begin
      n_err++; $display("FAIL reset_fmt_ext got %b want 0000", {b16.out_fmt, b16.out_ext});
    end
    n_cmp++;
    if (b16.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b want 1", b16.in_ready);
    end
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_r_format();
    do_reset();
    send(16'hF000, 1'b0);
    n_cmp++;
    if ({b16.out_valid, b16.out_imm, b16.out_fmt, b16.out_ext} !== {1'b1, 16'hFFFF, 3'b000, 1'b0})
    begin
      n_err++; $display("FAIL r16 got v=%b imm=%h fmt=%b ext=%b want v=1 imm=ffff fmt=000 ext=0",
                        b16.out_valid, b16.out_imm, b16.out_fmt, b16.out_ext);
    end
    n_cmp++;
    if (b32.out_imm !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL r32_imm got %h want ffffffff", b32.out_imm);
    end
    tick();
    n_cmp++;
    if (b16.out_valid !== 1'b0) begin
      n_err++; $display("FAIL r_drain got %b want 0", b16.out_valid);
    end
  endtask

  task automatic test_formats_back_to_back();
    do_reset();
    in_valid = 1'b1;
    in_instr = 16'h7FC6;
    tick();
    n_cmp++;
    if ({b16.out_valid, b16.out_imm, b16.out_fmt} !== {1'b1, 16'h01FF, 3'b110}) begin
      n_err++; $display("FAIL j_pos got v=%b imm=%h fmt=%b want v=1 imm=01ff fmt=110",
                        b16.out_valid, b16.out_imm, b16.out_fmt);
    end
    in_instr = 16'h8006;
    tick();
    n_cmp++;
    if ({b16.out_valid, b16.out_imm} !== {1'b1, 16'hFE00}) begin
      n_err++; $display("FAIL j_neg16 got v=%b imm=%h want v=1 imm=fe00",
                        b16.out_valid, b16.out_imm);
    end
    n_cmp++;
    if (b32.out_imm !== 32'hFFFFFE00) begin
      n_err++; $display("FAIL j_neg32 got %h want fffffe00", b32.out_imm);
    end
    in_instr = 16'hA001;
    tick();
    n_cmp++;
    if ({b16.out_imm, b16.out_fmt} !== {16'hFFF0, 3'b001}) begin
      n_err++; $display("FAIL i_fmt got imm=%h fmt=%b want imm=fff0 fmt=001",
                        b16.out_imm, b16.out_fmt);
    end
    in_instr = 16'h702C;
    tick();
    n_cmp++;
    if ({b32.out_imm, b32.out_fmt} !== {32'h0000003D, 3'b100}) begin
      n_err++; $display("FAIL y_fmt got imm=%h fmt=%b want imm=0000003d fmt=100",
                        b32.out_imm, b32.out_fmt);
    end
    idle();
    tick();
  endtask

  task automatic test_prefix();
    do_reset();
    send(16'h0008, 1'b1);
    n_cmp++;
    if ({b32.out_valid, b16.out_valid} !== 2'b00) begin
      n_err++; $display("FAIL pfx_no_out got %b want 00", {b32.out_valid, b16.out_valid});
    end
    n_cmp++;
    if ({bnp.out_valid, bnp.out_imm, bnp.out_ext} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++; $display("FAIL nopfx_tag_ignored got v=%b imm=%h ext=%b want v=1 imm=0000 ext=0",
                        bnp.out_valid, bnp.out_imm, bnp.out_ext);
    end
    send(16'h0202, 1'b0);
    n_cmp++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_ext} !==
        {1'b1, 32'h00000041, 3'b010, 1'b1}) begin
      n_err++; $display("FAIL pfx_m32 got v=%b imm=%h fmt=%b ext=%b want v=1 imm=00000041 fmt=010 ext=1",
                        b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_ext);
    end
    n_cmp++;
    if ({bnp.out_imm, bnp.out_ext} !== {16'h0001, 1'b0}) begin
      n_err++; $display("FAIL nopfx_m got imm=%h ext=%b want imm=0001 ext=0",
                        bnp.out_imm, bnp.out_ext);
    end
    // Negative payload on the widest format: sign-extended in 32, truncated in 16.
    send(16'h8000, 1'b1);
    send(16'h7FC6, 1'b0);
    n_cmp++;
    if (b32.out_imm !== 32'hFFE001FF) begin
      n_err++; $display("FAIL pfx_j32 got %h want ffe001ff", b32.out_imm);
    end
    n_cmp++;
    if ({b16.out_imm, b16.out_ext} !== {16'h01FF, 1'b1}) begin
      n_err++; $display("FAIL pfx_j16_trunc got imm=%h ext=%b want imm=01ff ext=1",
                        b16.out_imm, b16.out_ext);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    send(16'hF000, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h7FC6;
    #1;
    n_cmp++;
    if (b16.in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_in_ready got %b want 0", b16.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({b16.out_valid, b16.out_imm, b16.out_fmt} !== {1'b1, 16'hFFFF, 3'b000}) begin
        n_err++; $display("FAIL stall_hold_%0d got v=%b imm=%h fmt=%b want v=1 imm=ffff fmt=000",
                          i, b16.out_valid, b16.out_imm, b16.out_fmt);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (b16.in_ready !== 1'b1) begin
      n_err++; $display("FAIL release_in_ready got %b want 1", b16.in_ready);
    end
    tick();
    n_cmp++;
    if ({b16.out_valid, b16.out_imm} !== {1'b1, 16'h01FF}) begin
      n_err++; $display("FAIL release_next got v=%b imm=%h want v=1 imm=01ff",
                        b16.out_valid, b16.out_imm);
    end
    idle();
    tick();
    n_cmp++;
    if (b16.out_valid !== 1'b0) begin
      n_err++; $display("FAIL release_drain got %b want 0", b16.out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    send(16'hFFF8, 1'b1);
    // Word presented alongside flush must be dropped.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h7FC6;
    tick();
    flush = 1'b0;
    idle();
    n_cmp++;
    if (b16.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_drop got %b want 0", b16.out_valid);
    end
    send(16'h1000, 1'b0);
    n_cmp++;
    if ({b16.out_valid, b16.out_imm, b16.out_ext} !== {1'b1, 16'h0001, 1'b0}) begin
      n_err++; $display("FAIL flush_clears_pfx got v=%b imm=%h ext=%b want v=1 imm=0001 ext=0",
                        b16.out_valid, b16.out_imm, b16.out_ext);
    end
    // Flush during a stall discards the held beat.
    out_ready = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (b32.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_stall got %b want 0", b32.out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_double_prefix();
    do_reset();
    send(16'hF000, 1'b0);
    // Prefix accepted while the output drains: out_valid must fall.
    send(16'h0010, 1'b1);
    n_cmp++;
    if (b16.out_valid !== 1'b0) begin
      n_err++; $display("FAIL pfx_drain got %b want 0", b16.out_valid);
    end
    send(16'h0018, 1'b1);
    tick();
    tick();
    send(16'h0000, 1'b0);
    n_cmp++;
    if ({b16.out_valid, b16.out_imm, b16.out_fmt, b16.out_ext} !==
        {1'b1, 16'h0018, 3'b000, 1'b1}) begin
      n_err++; $display("FAIL double_pfx got v=%b imm=%h fmt=%b ext=%b want v=1 imm=0018 fmt=000 ext=1",
                        b16.out_valid, b16.out_imm, b16.out_fmt, b16.out_ext);
    end
    // Prefix was consumed; the next word is unprefixed.
    send(16'h0000, 1'b0);
    n_cmp++;
    if ({b16.out_imm, b16.out_ext} !== {16'h0000, 1'b0}) begin
      n_err++; $display("FAIL pfx_consumed got imm=%h ext=%b want imm=0000 ext=0",
                        b16.out_imm, b16.out_ext);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    test_reset();
    test_r_format();
    test_formats_back_to_back();
    test_prefix();
    test_stall();
    test_flush();
    test_double_prefix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
